// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared shift-unit select codes, data width and result-entry type
package alu_pkg;

  localparam int ALU_WIDTH = 4;

  localparam logic [1:0] SEL_LSL = 2'b00;
  localparam logic [1:0] SEL_LSR = 2'b01;
  localparam logic [1:0] SEL_ASR = 2'b10;
  localparam logic [1:0] SEL_INV = 2'b11;

  typedef struct packed {
    logic [ALU_WIDTH-1:0] result;
    logic [1:0]           sel;
    logic                 zero;
    logic                 neg;
    logic                 lost;
    logic                 invalid;
  } entry_t;

endpackage

// File: rtl/shift_flag_gen.sv
// rtl/shift_flag_gen.sv - builds a buffered result entry and its status flags from shifter operands
module shift_flag_gen
  import alu_pkg::*;
(
  input  logic [ALU_WIDTH-1:0] i_operand,
  input  logic [ALU_WIDTH-1:0] i_amount,
  input  logic [1:0]           i_sel,
  input  logic [ALU_WIDTH-1:0] i_result,
  output entry_t               o_entry
);

  localparam logic [ALU_WIDTH-1:0] ONES = '1;

  logic [ALU_WIDTH-1:0] w_left_mask;
  logic [ALU_WIDTH-1:0] w_right_mask;

  // Mask of bits that leave the word; an amount >= width yields an all-ones mask, zero yields none.
  assign w_left_mask  = ~(ONES >> i_amount);
  assign w_right_mask = ~(ONES << i_amount);

  always_comb begin
    o_entry     = '0;
    o_entry.sel = i_sel;
    if (i_sel == SEL_INV) begin
      o_entry.invalid = 1'b1;
      o_entry.zero    = 1'b1;
    end else begin
      o_entry.result = i_result;
      o_entry.zero   = (i_result == '0);
      o_entry.neg    = i_result[ALU_WIDTH-1];
      if (i_sel == SEL_LSL) begin
        o_entry.lost = |(i_operand & w_left_mask);
      end else begin
        o_entry.lost = |(i_operand & w_right_mask);
      end
    end
  end

endmodule

// File: rtl/shift_result_stage.sv
// rtl/shift_result_stage.sv - two-entry registered result buffer behind the shift unit with op counter
module shift_result_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_operand,
  input  logic [WIDTH-1:0] in_amount,
  input  logic [1:0]       in_sel,
  input  logic [WIDTH-1:0] in_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [1:0]       out_sel,
  output logic             out_zero,
  output logic             out_neg,
  output logic             out_lost,
  output logic             out_invalid,
  output logic [CNT_W-1:0] op_count,
  input  logic             cnt_clr
);

  entry_t           r_mem [2];
  logic             r_head;
  logic [1:0]       r_count;
  logic [CNT_W-1:0] r_op_count;

  entry_t w_entry;
  entry_t w_head;
  logic   w_push;
  logic   w_pop;
  logic   w_wr_idx;

  shift_flag_gen u_flag_gen (
    .i_operand (in_operand),
    .i_amount  (in_amount),
    .i_sel     (in_sel),
    .i_result  (in_result),
    .o_entry   (w_entry)
  );

  assign in_ready  = (r_count < 2'(DEPTH));
  assign out_valid = (r_count != 2'd0);
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;
  // Tail slot; at count=1 this is the slot the head moves to when a pop coincides.
  assign w_wr_idx  = r_head ^ r_count[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_head   <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[w_wr_idx] <= w_entry;
      end
      if (w_pop) begin
        r_head <= ~r_head;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_count <= '0;
    end else if (cnt_clr) begin
      r_op_count <= '0;
    end else if (w_pop && !(&r_op_count)) begin
      r_op_count <= r_op_count + 1'b1;
    end
  end

  assign w_head      = r_mem[r_head];
  assign out_result  = w_head.result;
  assign out_sel     = w_head.sel;
  assign out_zero    = w_head.zero;
  assign out_neg     = w_head.neg;
  assign out_lost    = w_head.lost;
  assign out_invalid = w_head.invalid;
  assign op_count    = r_op_count;

endmodule

// File: tb/tb_shift_result_stage.sv
// tb/tb_shift_result_stage.sv - scoreboard bench for shift_result_stage
module tb_shift_result_stage;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_operand;
  logic [3:0] in_amount;
  logic [1:0] in_sel;
  logic [3:0] in_result;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_result;
  logic [1:0] out_sel;
  logic       out_zero;
  logic       out_neg;
  logic       out_lost;
  logic       out_invalid;
  logic [1:0] op_count;
  logic       cnt_clr;

  int checks   = 0;
  int failures = 0;

  // expected entry: {result[3:0], sel[1:0], zero, neg, lost, invalid}
  logic [9:0] exp_q[$];

  shift_result_stage #(.WIDTH(4), .DEPTH(2), .CNT_W(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_operand  (in_operand),
    .in_amount   (in_amount),
    .in_sel      (in_sel),
    .in_result   (in_result),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_sel     (out_sel),
    .out_zero    (out_zero),
    .out_neg     (out_neg),
    .out_lost    (out_lost),
    .out_invalid (out_invalid),
    .op_count    (op_count),
    .cnt_clr     (cnt_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compare head against the scoreboard whenever a pop will occur at the next edge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL pop_unexpected: got %0h expected nothing",
                 {out_result, out_sel, out_zero, out_neg, out_lost, out_invalid});
      end else begin
        logic [9:0] e;
        logic [9:0] a;
        e = exp_q.pop_front();
        a = {out_result, out_sel, out_zero, out_neg, out_lost, out_invalid};
        if (a !== e) begin
          failures++;
          $display("FAIL pop_entry: got res=%b sel=%b z=%b n=%b l=%b i=%b expected res=%b sel=%b z=%b n=%b l=%b i=%b",
                   a[9:6], a[5:4], a[3], a[2], a[1], a[0], e[9:6], e[5:4], e[3], e[2], e[1], e[0]);
        end
      end
    end
  end

  task automatic push(input logic [3:0] a, input logic [3:0] b, input logic [1:0] s,
                      input logic [3:0] r, input logic [9:0] exp);
    logic rdy;
    logic done;
    done       = 1'b0;
    in_valid   = 1'b1;
    in_operand = a;
    in_amount  = b;
    in_sel     = s;
    in_result  = r;
    for (int k = 0; k < 20; k++) begin
      rdy = in_ready;
      @(posedge clk);
      #1;
      if (rdy) begin
        exp_q.push_back(exp);
        done = 1'b1;
        break;
      end
    end
    in_valid = 1'b0;
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL push_timeout: got in_ready=0 for 20 cycles expected acceptance");
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_operand = '0;
    in_amount  = '0;
    in_sel     = '0;
    in_result  = '0;
    out_ready  = 1'b0;
    cnt_clr    = 1'b0;
    #23;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", {out_result, out_sel, out_zero, out_neg, out_lost, out_invalid}, 0);
    check("rst_op_count", op_count, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    out_ready = 1'b1;
    push(4'b0011, 4'b0001, 2'b00, 4'b0110, {4'b0110, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0});
    check("lsl_visible", out_valid, 1);
    idle(1);
    check("lsl_op_count", op_count, 1);
    check("lsl_drained", out_valid, 0);

    push(4'b0011, 4'b0100, 2'b00, 4'b0000, {4'b0000, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0});
    push(4'b1100, 4'b0011, 2'b10, 4'b1111, {4'b1111, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0});
    push(4'b1000, 4'b0010, 2'b01, 4'b0010, {4'b0010, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0});
    push(4'b1110, 4'b0011, 2'b11, 4'b1010, {4'b0000, 2'b11, 1'b1, 1'b0, 1'b0, 1'b1});
    idle(2);
    check("cnt_saturated", op_count, 3);

    push(4'b0001, 4'b0000, 2'b00, 4'b0001, {4'b0001, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0});
    cnt_clr = 1'b1;
    idle(1);
    cnt_clr = 1'b0;
    check("clr_with_pop", op_count, 0);
    check("clr_pop_done", out_valid, 0);

    out_ready = 1'b0;
    push(4'b0111, 4'b0001, 2'b01, 4'b0011, {4'b0011, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0});
    check("bp_ready_after_a", in_ready, 1);
    push(4'b1001, 4'b0101, 2'b10, 4'b1111, {4'b1111, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0});
    check("bp_ready_after_b", in_ready, 0);
    in_valid   = 1'b1;
    in_operand = 4'b1010;
    in_amount  = 4'b0010;
    in_sel     = 2'b00;
    in_result  = 4'b1000;
    idle(1);
    check("bp_ready_held", in_ready, 0);
    check("bp_head_stable", out_result, 4'b0011);
    out_ready = 1'b1;
    push(4'b1010, 4'b0010, 2'b00, 4'b1000, {4'b1000, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0});
    check("bp_pushpop_valid", out_valid, 1);
    check("bp_pushpop_ready", in_ready, 1);
    check("bp_pushpop_head", out_result, 4'b1000);
    idle(1);
    check("bp_drained", out_valid, 0);
    check("bp_op_count", op_count, 3);

    out_ready = 1'b0;
    push(4'b0001, 4'b0001, 2'b00, 4'b0010, {4'b0010, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0});
    push(4'b0010, 4'b0001, 2'b01, 4'b0001, {4'b0001, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0});
    check("rst_pre_full", in_ready, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_ready", in_ready, 1);
    check("async_rst_count", op_count, 0);
    exp_q.delete();
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    out_ready = 1'b1;
    idle(2);
    check("post_rst_empty", out_valid, 0);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
